instruction_fetch: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the program counter (PC) and drives address/enable into instruction_memory, which has a 1-cycle registered read.
- Captures returned words into a 2-entry buffer and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles branch redirects (flushes wrong-path fetches) and stops fetching on a HALT instruction.

---
 rtl/vr16_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/instruction_fetch.sv | 112 +++++++++++
 tb/tb_instruction_fetch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vr16_pkg.sv
// Shared constants and types for the vr16 fetch front end.
// Holds bus widths, the opcode field position and the fetch FSM encoding.
package vr16_pkg;

    localparam int VR16_ADDR_W  = 16;
    localparam int VR16_INSTR_W = 16;
    localparam int OPCODE_MSB   = 15;
    localparam int OPCODE_LSB   = 12;

    localparam logic [3:0]             VR16_HALT_OPCODE = 4'hF;
    localparam logic [VR16_ADDR_W-1:0] VR16_RESET_PC    = 16'h0000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic logic is_opcode(input logic [VR16_INSTR_W-1:0] word,
                                       input logic [3:0] opcode);
        return word[OPCODE_MSB:OPCODE_LSB] == opcode;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instruction} pairs.
// Push and pop may coincide at any occupancy; flush empties it in one cycle.
module fetch_queue #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full queue is only accepted when the head leaves this cycle.
    assign do_push = push_i & (~full | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a 1-cycle registered instruction memory and
// hands {pc, instruction} to decode; handles branch redirects and HALT.
module instruction_fetch
    import vr16_pkg::*;
#(
    parameter int                ADDR_W      = VR16_ADDR_W,
    parameter int                INSTR_W     = VR16_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = VR16_RESET_PC,
    parameter logic [3:0]        HALT_OPCODE = VR16_HALT_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_enable,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] fetch_instruction,
    output logic [ADDR_W-1:0]  fetch_pc,
    input  logic               fetch_ready,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic [1:0]        q_count;
    logic              q_empty;
    logic [2:0]        occ_after_pop;
    logic              pop;
    logic              issue;
    logic              capture;

    fetch_queue #(
        .W(ADDR_W + INSTR_W)
    ) u_queue (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (capture),
        .data_i  ({inflight_pc_q, imem_instruction}),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_o  ({fetch_pc, fetch_instruction}),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    assign fetch_valid = ~q_empty;
    assign pop         = fetch_valid & fetch_ready;
    assign halted      = (state_q == HALTED);

    // Occupancy once this cycle's pop leaves; pop implies count >= 1, so no underflow.
    assign occ_after_pop = {1'b0, q_count} + {2'b0, inflight_q} - {2'b0, pop};

    assign issue = ~reset & (state_q == RUN) & ~redirect_valid & (occ_after_pop <= 3'd1);
    assign imem_enable  = issue;
    assign imem_address = pc_q;

    // Words returning behind a HALT or alongside a redirect are wrong-path.
    assign capture = inflight_q & ~redirect_valid & (state_q == RUN);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        if (issue) begin
            pc_d          = pc_q + 1'b1;
            inflight_pc_d = pc_q;
        end

        case (state_q)
            RUN: begin
                if (capture && is_opcode(imem_instruction, HALT_OPCODE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && is_opcode(fetch_instruction, HALT_OPCODE)) begin
                    state_d = HALTED;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase

        if (redirect_valid) begin
            state_d    = RUN;
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a registered-read memory model and
// a queue of delivered {pc, instruction} pairs compared against expectations.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_enable;
    logic [15:0] imem_address;
    logic [15:0] imem_instruction;
    logic        fetch_valid;
    logic [15:0] fetch_instruction;
    logic [15:0] fetch_pc;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;

    logic [15:0] imem [0:65535];
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .imem_enable       (imem_enable),
        .imem_address      (imem_address),
        .imem_instruction  (imem_instruction),
        .fetch_valid       (fetch_valid),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .fetch_ready       (fetch_ready),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .halted            (halted)
    );

    always @(posedge clk) begin
        if (imem_enable) imem_instruction <= imem[imem_address];
    end

    always @(negedge clk) begin
        if (!reset && fetch_valid && fetch_ready) got_q.push_back({fetch_pc, fetch_instruction});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        step();
        step();
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            step();
            c++;
        end
        check(tag, (got_q.size() >= n), 1);
    endtask

    task automatic compare_q(input string tag, input bit exact);
        int n;
        if (exact) check({tag, "_len"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) imem[i] = 16'h1000 | 16'((i + 1) & 32'h0FFF);
        fetch_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;

        // Reset state while reset is held
        reset = 1'b1;
        step();
        step();
        check("rst_enable", imem_enable, 0);
        check("rst_valid", fetch_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", fetch_pc, 0);
        check("rst_instr", fetch_instruction, 0);

        // Streaming from reset, no bubbles
        fetch_ready = 1'b1;
        do_reset();
        #1;
        check("s_c0_en", imem_enable, 1);
        check("s_c0_addr", imem_address, 16'h0000);
        check("s_c0_valid", fetch_valid, 0);
        step(); #1;
        check("s_c1_addr", imem_address, 16'h0001);
        check("s_c1_valid", fetch_valid, 0);
        step(); #1;
        check("s_c2_valid", fetch_valid, 1);
        check("s_c2_head", {fetch_pc, fetch_instruction}, {16'h0000, 16'h1001});
        check("s_c2_addr", imem_address, 16'h0002);
        step(); #1;
        check("s_c3_head", {fetch_valid, fetch_pc, fetch_instruction}, {1'b1, 16'h0001, 16'h1002});
        step(); #1;
        check("s_c4_head", {fetch_valid, fetch_pc, fetch_instruction}, {1'b1, 16'h0002, 16'h1003});

        // Backpressure: buffer fills, fetch stops, order preserved on release
        fetch_ready = 1'b0;
        do_reset();
        step();
        step(); #1;
        check("bp_c2_valid", fetch_valid, 1);
        check("bp_c2_pc", fetch_pc, 16'h0000);
        check("bp_c2_en", imem_enable, 0);
        for (int i = 3; i <= 6; i++) begin
            step(); #1;
            check($sformatf("bp_c%0d_en", i), imem_enable, 0);
            check($sformatf("bp_c%0d_pc", i), fetch_pc, 16'h0000);
        end
        step();
        fetch_ready = 1'b1;
        #1;
        check("bp_release_en", imem_enable, 1);
        check("bp_release_addr", imem_address, 16'h0002);
        exp_q = '{{16'h0000, 16'h1001}, {16'h0001, 16'h1002}, {16'h0002, 16'h1003}, {16'h0003, 16'h1004}};
        wait_got(4, 20, "bp_timeout");
        compare_q("bp_order", 1'b0);

        // Redirect with one buffered entry and one in flight
        fetch_ready = 1'b0;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        check("rd_cycle_en", imem_enable, 0);
        step();
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        #1;
        check("rd_next_valid", fetch_valid, 0);
        check("rd_next_en", imem_enable, 1);
        check("rd_next_addr", imem_address, 16'h0040);
        exp_q = '{{16'h0040, 16'h1041}, {16'h0041, 16'h1042}, {16'h0042, 16'h1043}};
        wait_got(3, 20, "rd_timeout");
        compare_q("rd_order", 1'b0);

        // HALT at pc 3: delivered, the word behind it dropped, then restart
        imem[3]     = 16'hF000;
        fetch_ready = 1'b1;
        do_reset();
        begin
            int c = 0;
            #1;
            while (!(fetch_valid && fetch_instruction == 16'hF000) && c < 12) begin
                step(); #1;
                c++;
            end
        end
        check("h_head", {fetch_valid, fetch_pc, fetch_instruction}, {1'b1, 16'h0003, 16'hF000});
        check("h_pre_halted", halted, 0);
        check("h_drain_en", imem_enable, 0);
        step(); #1;
        check("h_halted", halted, 1);
        check("h_valid", fetch_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check($sformatf("h_hold%0d", i), {halted, imem_enable, fetch_valid}, 3'b100);
        end
        exp_q = '{{16'h0000, 16'h1001}, {16'h0001, 16'h1002}, {16'h0002, 16'h1003}, {16'h0003, 16'hF000}};
        compare_q("h_delivered", 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        #1;
        check("h_redirect_en", imem_enable, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("h_resume_halted", halted, 0);
        check("h_resume_en", imem_enable, 1);
        check("h_resume_addr", imem_address, 16'h0010);
        got_q.delete();
        exp_q = '{{16'h0010, 16'h1011}};
        wait_got(1, 20, "h_resume_timeout");
        compare_q("h_resume", 1'b0);
        imem[3] = 16'h1004;

        // PC wrap-around
        fetch_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        check("w_addr_fffe", imem_address, 16'hFFFE);
        step(); #1;
        check("w_addr_ffff", imem_address, 16'hFFFF);
        step(); #1;
        check("w_addr_0000", {imem_enable, imem_address}, {1'b1, 16'h0000});
        exp_q = '{{16'hFFFE, 16'h1FFF}, {16'hFFFF, 16'h1000}, {16'h0000, 16'h1001}};
        wait_got(3, 20, "w_timeout");
        compare_q("w_order", 1'b0);

        // One-cycle reset mid-stream with a request in flight
        fetch_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step(); #1;
        check("mr_valid", fetch_valid, 0);
        check("mr_halted", halted, 0);
        check("mr_en", imem_enable, 0);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        #1;
        check("mr_first_addr", {imem_enable, imem_address}, {1'b1, 16'h0000});
        exp_q = '{{16'h0000, 16'h1001}, {16'h0001, 16'h1002}};
        wait_got(2, 20, "mr_timeout");
        compare_q("mr_order", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
